// File: rtl/sram_arbiter.sv
// N-channel round-robin arbiter and strobe sequencer for a 16-bit async SRAM.
// Define SRAM_ARB_FIXED_PRIO_EN to give channel 0 absolute priority over the others.
module sram_arbiter #(
  parameter int NUM_CH      = 2,
  parameter int ADDR_W      = 17,
  parameter int DATA_W      = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic                       clk_vga,
  input  logic                       rst_n,
  input  logic [NUM_CH-1:0]          req,
  input  logic [NUM_CH-1:0]          we,
  input  logic [NUM_CH*ADDR_W-1:0]   adr,
  input  logic [NUM_CH*DATA_W-1:0]   dat_i,
  output logic [NUM_CH-1:0]          ack,
  output logic [DATA_W-1:0]          dat_o,
  output logic                       sram_cs_n,
  output logic                       sram_we_n,
  output logic                       sram_oe_n,
  output logic [ADDR_W-1:0]          sram_adr,
  output logic [DATA_W-1:0]          sram_dat_o,
  output logic                       sram_dat_oe,
  input  logic [DATA_W-1:0]          sram_dat_i
);

  // state  | meaning
  // IDLE   | bus released, sample requests and pick a grant
  // SETUP  | cs_n low, address (and write data) set up, strobes high
  // ACCESS | oe_n or we_n low for WAIT_STATES+1 cycles, down-counter times it
  // HOLD   | strobes high, address/data held, one-cycle ack to granted channel
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  state_t              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [PTR_W-1:0]    gnt_q, gnt_d;
  logic                wr_q, wr_d;
  logic                cs_n_q, cs_n_d;
  logic                we_n_q, we_n_d;
  logic                oe_n_q, oe_n_d;
  logic [ADDR_W-1:0]   adr_q, adr_d;
  logic [DATA_W-1:0]   wdat_q, wdat_d;
  logic                dat_oe_q, dat_oe_d;
  logic [NUM_CH-1:0]   ack_q, ack_d;
  logic [DATA_W-1:0]   dat_o_q, dat_o_d;

  logic [NUM_CH-1:0]   cand;
  logic                found;
  int                  sel_i;
  int                  idx;

  // Round-robin search starting at the pointer; channel 0 bypasses it in fixed-priority builds.
  always_comb begin
    cand  = req;
    found = 1'b0;
    sel_i = 0;
    idx   = 0;
`ifdef SRAM_ARB_FIXED_PRIO_EN
    if (req[0]) begin
      found = 1'b1;
      cand  = '0;
    end else begin
      cand  = req & ~NUM_CH'(1);
    end
`endif
    for (int i = 0; i < NUM_CH; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!found && cand[idx]) begin
        found = 1'b1;
        sel_i = idx;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    wr_d     = wr_q;
    cs_n_d   = cs_n_q;
    we_n_d   = we_n_q;
    oe_n_d   = oe_n_q;
    adr_d    = adr_q;
    wdat_d   = wdat_q;
    dat_oe_d = dat_oe_q;
    ack_d    = '0;
    dat_o_d  = dat_o_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          gnt_d    = PTR_W'(sel_i);
          wr_d     = we[sel_i];
          adr_d    = adr[sel_i*ADDR_W +: ADDR_W];
          wdat_d   = dat_i[sel_i*DATA_W +: DATA_W];
          dat_oe_d = we[sel_i];
          cs_n_d   = 1'b0;
`ifdef SRAM_ARB_FIXED_PRIO_EN
          if (sel_i != 0) ptr_d = PTR_W'((sel_i + 1) % NUM_CH);
`else
          ptr_d    = PTR_W'((sel_i + 1) % NUM_CH);
`endif
          state_d  = SETUP;
        end
      end
      SETUP: begin
        cnt_d = 3'(WAIT_STATES);
        if (wr_q) we_n_d = 1'b0;
        else      oe_n_d = 1'b0;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (cnt_q == 3'd0) begin
          we_n_d       = 1'b1;
          oe_n_d       = 1'b1;
          ack_d[gnt_q] = 1'b1;
          if (!wr_q) dat_o_d = sram_dat_i;
          state_d      = HOLD;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      HOLD: begin
        cs_n_d   = 1'b1;
        dat_oe_d = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ptr_q    <= '0;
      gnt_q    <= '0;
      wr_q     <= 1'b0;
      cs_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      adr_q    <= '0;
      wdat_q   <= '0;
      dat_oe_q <= 1'b0;
      ack_q    <= '0;
      dat_o_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      wr_q     <= wr_d;
      cs_n_q   <= cs_n_d;
      we_n_q   <= we_n_d;
      oe_n_q   <= oe_n_d;
      adr_q    <= adr_d;
      wdat_q   <= wdat_d;
      dat_oe_q <= dat_oe_d;
      ack_q    <= ack_d;
      dat_o_q  <= dat_o_d;
    end
  end

  assign ack         = ack_q;
  assign dat_o       = dat_o_q;
  assign sram_cs_n   = cs_n_q;
  assign sram_we_n   = we_n_q;
  assign sram_oe_n   = oe_n_q;
  assign sram_adr    = adr_q;
  assign sram_dat_o  = wdat_q;
  assign sram_dat_oe = dat_oe_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: timing, round-robin order, async abort and wait-state variants.
// Honours SRAM_ARB_FIXED_PRIO_EN for the expected grant order.
module tb_sram_arbiter;

  logic        clk_vga = 1'b0;
  logic        rst_n;
  logic [1:0]  req, we, ack;
  logic [33:0] adr;
  logic [31:0] dat_i;
  logic [15:0] dat_o, sram_dat_o, sram_dat_i;
  logic        sram_cs_n, sram_we_n, sram_oe_n, sram_dat_oe;
  logic [16:0] sram_adr;

  logic        req_a, req_b, ack_a, ack_b;
  logic [16:0] adr_a, adr_b, sadr_a, sadr_b;
  logic [15:0] dato_a, dato_b, sdo_a, sdo_b;
  logic        cs_a, we_a, oe_a, doe_a, cs_b, we_b, oe_b, doe_b;

  logic [15:0] mem [256];
  int n_cmp = 0, n_bad = 0;
  int n_overlap = 0, n_unstable = 0;
  logic        strb_prev = 1'b0;
  logic [16:0] adr_prev = '0;
  logic [15:0] dat_prev = '0;

  always #5 clk_vga = ~clk_vga;

  sram_arbiter #(.NUM_CH(2), .ADDR_W(17), .DATA_W(16), .WAIT_STATES(1)) dut (
    .clk_vga(clk_vga), .rst_n(rst_n), .req(req), .we(we), .adr(adr), .dat_i(dat_i),
    .ack(ack), .dat_o(dat_o), .sram_cs_n(sram_cs_n), .sram_we_n(sram_we_n),
    .sram_oe_n(sram_oe_n), .sram_adr(sram_adr), .sram_dat_o(sram_dat_o),
    .sram_dat_oe(sram_dat_oe), .sram_dat_i(sram_dat_i));

  sram_arbiter #(.NUM_CH(1), .ADDR_W(17), .DATA_W(16), .WAIT_STATES(0)) u_ws0 (
    .clk_vga(clk_vga), .rst_n(rst_n), .req(req_a), .we(1'b0), .adr(adr_a), .dat_i(16'h0),
    .ack(ack_a), .dat_o(dato_a), .sram_cs_n(cs_a), .sram_we_n(we_a), .sram_oe_n(oe_a),
    .sram_adr(sadr_a), .sram_dat_o(sdo_a), .sram_dat_oe(doe_a), .sram_dat_i(16'hC0DE));

  sram_arbiter #(.NUM_CH(1), .ADDR_W(17), .DATA_W(16), .WAIT_STATES(3)) u_ws3 (
    .clk_vga(clk_vga), .rst_n(rst_n), .req(req_b), .we(1'b0), .adr(adr_b), .dat_i(16'h0),
    .ack(ack_b), .dat_o(dato_b), .sram_cs_n(cs_b), .sram_we_n(we_b), .sram_oe_n(oe_b),
    .sram_adr(sadr_b), .sram_dat_o(sdo_b), .sram_dat_oe(doe_b), .sram_dat_i(16'h3A3A));

  // SRAM model: read data only while oe_n low; a write commits on the we_n rising edge
  // with cs_n still low, so a reset-aborted cycle leaves memory untouched.
  assign sram_dat_i = sram_oe_n ? 16'h0000 : mem[sram_adr[7:0]];
  always @(posedge sram_we_n) begin
    if (rst_n && !sram_cs_n) mem[sram_adr[7:0]] = sram_dat_o;
  end

  always @(negedge clk_vga) begin
    if (!sram_we_n && !sram_oe_n) n_overlap++;
    if (strb_prev && (!sram_we_n || !sram_oe_n) && (sram_adr != adr_prev || sram_dat_o != dat_prev))
      n_unstable++;
    strb_prev = !sram_we_n || !sram_oe_n;
    adr_prev  = sram_adr;
    dat_prev  = sram_dat_o;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Single-channel access; reports ack latency, strobe widths and ack count over a 12-cycle window.
  task automatic run_access(input int ch, input bit wr, input logic [16:0] a, input logic [15:0] d,
                            output int lat, output int oe_c, output int we_c, output int ack_c);
    req = '0;
    we  = '0;
    adr[ch*17 +: 17]   = a;
    dat_i[ch*16 +: 16] = d;
    we[ch]  = wr;
    req[ch] = 1'b1;
    lat = -1; oe_c = 0; we_c = 0; ack_c = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk_vga);
      if (!sram_oe_n) oe_c++;
      if (!sram_we_n) we_c++;
      if (c == 1) begin
        chk("setup_cs", 32'(sram_cs_n), 32'd0);
        chk("setup_strb", 32'({sram_we_n, sram_oe_n}), 32'd3);
        chk("setup_adr", 32'(sram_adr), 32'(a));
        chk("setup_doe", 32'(sram_dat_oe), 32'(wr));
      end
      if (ack[ch]) begin
        ack_c++;
        if (lat < 0) lat = c;
        req[ch] = 1'b0;
        chk("hold_adr", 32'(sram_adr), 32'(a));
        if (wr) chk("hold_dat", 32'(sram_dat_o), 32'(d));
      end
      if (lat > 0 && c == lat + 1) begin
        chk("idle_cs", 32'(sram_cs_n), 32'd1);
        chk("idle_doe", 32'(sram_dat_oe), 32'd0);
      end
    end
    req = '0;
  endtask

  initial begin
    int lat, oe_c, we_c, ack_c, n, last, g, ack_seen, cs_low;
    int order [4];
    int exp_ord [4];
    int lat_a, lat_b, oe_ca, oe_cb;
`ifdef SRAM_ARB_FIXED_PRIO_EN
    exp_ord = '{0, 0, 0, 0};
`else
    exp_ord = '{0, 1, 0, 1};
`endif
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h10] = 16'hBEEF;
    mem[8'h20] = 16'hAAAA;
    mem[8'h30] = 16'h5555;
    mem[8'h40] = 16'h1111;
    rst_n = 1'b0; req = '0; we = '0; adr = '0; dat_i = '0;
    req_a = 1'b0; req_b = 1'b0; adr_a = 17'h5; adr_b = 17'h6;
    order = '{default: -1};

    repeat (2) @(negedge clk_vga);
    chk("rst_cs", 32'(sram_cs_n), 32'd1);
    chk("rst_we", 32'(sram_we_n), 32'd1);
    chk("rst_oe", 32'(sram_oe_n), 32'd1);
    chk("rst_doe", 32'(sram_dat_oe), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_dat_o", 32'(dat_o), 32'd0);
    chk("rst_adr", 32'(sram_adr), 32'd0);
    chk("rst_sdo", 32'(sram_dat_o), 32'd0);
    rst_n = 1'b1;
    @(negedge clk_vga);

    run_access(0, 1'b0, 17'h00010, 16'h0, lat, oe_c, we_c, ack_c);
    chk("rd_lat", 32'(lat), 32'd4);
    chk("rd_oe_w", 32'(oe_c), 32'd2);
    chk("rd_we_w", 32'(we_c), 32'd0);
    chk("rd_acks", 32'(ack_c), 32'd1);
    chk("rd_data", 32'(dat_o), 32'hBEEF);

    run_access(1, 1'b1, 17'h1FFFF, 16'h1234, lat, oe_c, we_c, ack_c);
    chk("wr_lat", 32'(lat), 32'd4);
    chk("wr_we_w", 32'(we_c), 32'd2);
    chk("wr_oe_w", 32'(oe_c), 32'd0);
    chk("wr_acks", 32'(ack_c), 32'd1);
    chk("wr_dat_o_hold", 32'(dat_o), 32'hBEEF);
    chk("wr_mem", 32'(mem[8'hFF]), 32'h1234);
    run_access(1, 1'b0, 17'h1FFFF, 16'h0, lat, oe_c, we_c, ack_c);
    chk("rb_data", 32'(dat_o), 32'h1234);

    // Both channels requesting back to back: each drops req for one cycle after its ack.
    we = '0;
    adr[16:0] = 17'h20;
    adr[33:17] = 17'h30;
    req = 2'b11;
    n = 0; last = 0;
    for (int c = 1; c <= 40 && n < 4; c++) begin
      @(negedge clk_vga);
      if (|ack) begin
        g = ack[1] ? 1 : 0;
        order[n] = g;
        chk("rr_data", 32'(dat_o), (g == 1) ? 32'h5555 : 32'hAAAA);
        if (n > 0) chk("rr_slot", 32'(c - last), 32'd5);
        last = c;
        n++;
        req[g] = 1'b0;
        if (n == 4) req = '0;
      end else begin
        req = 2'b11;
      end
    end
    req = '0;
    chk("rr_count", 32'(n), 32'd4);
    for (int i = 0; i < 4; i++) chk("rr_order", 32'(order[i]), 32'(exp_ord[i]));
    repeat (3) @(negedge clk_vga);

    // Reset during the write strobe aborts the access.
    we = 2'b01; adr[16:0] = 17'h40; dat_i[15:0] = 16'h9999; req = 2'b01;
    @(negedge clk_vga);
    @(negedge clk_vga);
    chk("pre_rst_we", 32'(sram_we_n), 32'd0);
    #1 rst_n = 1'b0;
    req = '0;
    #1;
    chk("abort_we", 32'(sram_we_n), 32'd1);
    chk("abort_cs", 32'(sram_cs_n), 32'd1);
    chk("abort_doe", 32'(sram_dat_oe), 32'd0);
    chk("abort_ack", 32'(ack), 32'd0);
    ack_seen = 0; cs_low = 0;
    repeat (2) begin
      @(negedge clk_vga);
      if (|ack) ack_seen++;
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk_vga);
      if (|ack) ack_seen++;
      if (!sram_cs_n) cs_low++;
    end
    chk("abort_no_ack", 32'(ack_seen), 32'd0);
    chk("abort_idle", 32'(cs_low), 32'd0);
    chk("abort_mem", 32'(mem[8'h40]), 32'h1111);
    run_access(0, 1'b0, 17'h40, 16'h0, lat, oe_c, we_c, ack_c);
    chk("post_abort_lat", 32'(lat), 32'd4);
    chk("post_abort_data", 32'(dat_o), 32'h1111);

    // Wait-state variants run side by side.
    req_a = 1'b1; req_b = 1'b1;
    lat_a = -1; lat_b = -1; oe_ca = 0; oe_cb = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk_vga);
      if (!oe_a) oe_ca++;
      if (!oe_b) oe_cb++;
      if (ack_a && lat_a < 0) begin lat_a = c; req_a = 1'b0; chk("ws0_data", 32'(dato_a), 32'hC0DE); end
      if (ack_b && lat_b < 0) begin lat_b = c; req_b = 1'b0; chk("ws3_data", 32'(dato_b), 32'h3A3A); end
    end
    req_a = 1'b0; req_b = 1'b0;
    chk("ws0_lat", 32'(lat_a), 32'd3);
    chk("ws0_oe_w", 32'(oe_ca), 32'd1);
    chk("ws3_lat", 32'(lat_b), 32'd6);
    chk("ws3_oe_w", 32'(oe_cb), 32'd4);

    chk("no_overlap", 32'(n_overlap), 32'd0);
    chk("adr_stable", 32'(n_unstable), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
